// File: rtl/color_seq_pkg.sv
// Shared types and constants for the WS2812 palette sequencer.
package color_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FADE = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    localparam int N_DEFAULT = 5;

    localparam rgb8_t DEFAULT_PALETTE [N_DEFAULT] = '{
        '{r: 8'hFF, g: 8'hFF, b: 8'hFF},
        '{r: 8'h00, g: 8'h00, b: 8'hFF},
        '{r: 8'h00, g: 8'h00, b: 8'h00},
        '{r: 8'hFF, g: 8'h00, b: 8'h00},
        '{r: 8'hFF, g: 8'hFF, b: 8'h00}
    };

    // Entries beyond the built-in table come up black.
    function automatic rgb8_t default_rgb(input int i);
        case (i)
            0:       return DEFAULT_PALETTE[0];
            1:       return DEFAULT_PALETTE[1];
            2:       return DEFAULT_PALETTE[2];
            3:       return DEFAULT_PALETTE[3];
            4:       return DEFAULT_PALETTE[4];
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/color_lerp.sv
// One-channel linear blend: out = a + ((b - a) * step) >>> STEP_BITS.
module color_lerp #(
    parameter int CW        = 8,
    parameter int STEP_BITS = 5
) (
    input  logic [CW-1:0]        a_i,
    input  logic [CW-1:0]        b_i,
    input  logic [STEP_BITS-1:0] step_i,
    output logic [CW-1:0]        out_o
);
    localparam int PW = CW + STEP_BITS + 1;

    logic signed [CW:0]   diff;
    logic signed [PW-1:0] prod;

    assign diff = $signed({1'b0, b_i}) - $signed({1'b0, a_i});
    assign prod = PW'(diff) * PW'($signed({1'b0, step_i}));

    // Floor shift keeps the result between a and b, so truncation is safe.
    assign out_o = CW'($signed({{(STEP_BITS + 1){1'b0}}, a_i}) + (prod >>> STEP_BITS));

endmodule

// File: rtl/color_sequencer.sv
// Palette sequencer: holds each entry for HOLD_FRAMES frames, then fades to the next,
// emitting one RGB frame per valid/ready handshake.
module color_sequencer
    import color_seq_pkg::*;
#(
    parameter int N_COLORS    = 5,
    parameter int CW          = 8,
    parameter int STEP_BITS   = 5,
    parameter int HOLD_FRAMES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        one_shot,
    input  logic                        pal_we,
    input  logic [$clog2(N_COLORS)-1:0] pal_addr,
    input  logic [3*CW-1:0]             pal_wdata,
    output logic [3*CW-1:0]             pix_rgb,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [$clog2(N_COLORS)-1:0] cur_index,
    output logic                        busy,
    output logic                        done
);
    localparam int IW = $clog2(N_COLORS);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_COLORS - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD_FRAMES - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [STEP_BITS-1:0]   step_q, step_d;
    logic                   one_shot_q, one_shot_d;
    logic [3*CW-1:0]        rgb_q, rgb_d;
    logic                   valid_q;
    logic                   done_q;
    logic                   load;
    logic                   accept;
    logic [3*CW-1:0]        palette_q [N_COLORS];
    logic [3*CW-1:0]        blend;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [3*CW-1:0] expand(input rgb8_t c);
        return {{CW{|c.r}}, {CW{|c.g}}, {CW{|c.b}}};
    endfunction

    assign accept = valid_q && pix_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        step_d     = step_q;
        one_shot_d = one_shot_q;
        load       = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = HOLD;
                    idx_d      = '0;
                    hold_d     = '0;
                    step_d     = '0;
                    one_shot_d = one_shot;
                    load       = 1'b1;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (hold_q == LAST_HOLD) begin
                        if (one_shot_q && idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            state_d = FADE;
                            step_d  = STEP_BITS'(1);
                            load    = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                        load   = 1'b1;
                    end
                end
            end
            FADE: begin
                if (accept) begin
                    load = 1'b1;
                    if (step_q == {STEP_BITS{1'b1}}) begin
                        state_d = HOLD;
                        idx_d   = next_idx(idx_q);
                        hold_d  = '0;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
            idx_d   = '0;
            load    = 1'b0;
        end
    end

    // Next frame is built from the post-transition index/step and the current palette.
    for (genvar ch = 0; ch < 3; ch++) begin : g_lerp
        color_lerp #(.CW(CW), .STEP_BITS(STEP_BITS)) u_lerp (
            .a_i   (palette_q[idx_d][ch*CW +: CW]),
            .b_i   (palette_q[next_idx(idx_d)][ch*CW +: CW]),
            .step_i(step_d),
            .out_o (blend[ch*CW +: CW])
        );
    end

    assign rgb_d = (state_d == FADE) ? blend : palette_q[idx_d];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            step_q     <= '0;
            one_shot_q <= 1'b0;
            rgb_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            step_q     <= step_d;
            one_shot_q <= one_shot_d;
            valid_q    <= (state_d == HOLD) || (state_d == FADE);
            done_q     <= (state_d == DONE);
            if (stop) begin
                rgb_q <= '0;
            end else if (load) begin
                rgb_q <= rgb_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COLORS; i++) begin
                palette_q[i] <= expand(default_rgb(i));
            end
        end else if (pal_we && (32'(pal_addr) < N_COLORS)) begin
            palette_q[pal_addr] <= pal_wdata;
        end
    end

    assign pix_rgb   = rgb_q;
    assign pix_valid = valid_q;
    assign busy      = valid_q;
    assign done      = done_q;
    assign cur_index = idx_q;

endmodule
